// File: rtl/ram_busctl_if.sv
// Request/response handshake between a master engine and ram_busctl.
`timescale 1ns/1ps
interface ram_busctl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;

  modport master (output req_valid, req_we, req_addr, req_wdata,
                  input  req_ready, rsp_valid, rsp_rdata);
  modport slave  (input  req_valid, req_we, req_addr, req_wdata,
                  output req_ready, rsp_valid, rsp_rdata);
endinterface

// File: rtl/ram_busctl.sv
// RAM bus sequencer: SETUP -> ACCESS (WAIT+1 cycles) -> TURN (reads only).
// Optional RAM_BUSCTL_STATS_EN adds saturating rd/wr/busy counters.
`timescale 1ns/1ps
module ram_busctl #(
  parameter int WAIT = 0
) (
  input  logic        clk,
  input  logic        rst,
  ram_busctl_if.slave bus,
  output logic [15:0] addr,
  inout  wire  [7:0]  data,
  output logic        cs,
  output logic        oe,
  output logic        we
`ifdef RAM_BUSCTL_STATS_EN
  ,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count,
  output logic [15:0] busy_cycles
`endif
);

  generate
    if (WAIT < 0 || WAIT > 15) begin : g_bad_wait
      $error("ram_busctl: WAIT must be in 0..15");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, TURN} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        lat_we;
  logic [15:0] lat_addr;
  logic [7:0]  lat_wdata;
  logic        rsp_valid_q;
  logic [7:0]  rsp_rdata_q;
  logic        last_acc;
  logic        drive;

  assign last_acc = (state == ACCESS) && (cnt == 4'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      lat_we      <= 1'b0;
      lat_addr    <= 16'd0;
      lat_wdata   <= 8'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'd0;
    end else begin
      state       <= state_nxt;
      rsp_valid_q <= last_acc;
      if (state == IDLE && bus.req_valid) begin
        lat_we    <= bus.req_we;
        lat_addr  <= bus.req_addr;
        lat_wdata <= bus.req_wdata;
      end
      if (state == SETUP)
        cnt <= 4'(WAIT);
      else if (state == ACCESS && cnt != 4'd0)
        cnt <= cnt - 4'd1;
      // Read data is sampled at the edge closing the final ACCESS cycle.
      if (last_acc && !lat_we)
        rsp_rdata_q <= data;
    end
  end

  always_comb begin
    state_nxt = state;
    cs        = 1'b0;
    oe        = 1'b0;
    we        = 1'b0;
    drive     = 1'b0;
    case (state)
      IDLE:   if (bus.req_valid) state_nxt = SETUP;
      SETUP: begin
        drive     = lat_we;
        state_nxt = ACCESS;
      end
      ACCESS: begin
        cs    = 1'b1;
        oe    = !lat_we;
        we    = lat_we;
        drive = lat_we;
        if (cnt == 4'd0) state_nxt = lat_we ? IDLE : TURN;
      end
      TURN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Gated by rst so ready is low for the whole reset window, not just after it.
  assign bus.req_ready = (state == IDLE) && rst;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign addr          = lat_addr;
  assign data          = drive ? lat_wdata : 8'bz;

`ifdef RAM_BUSCTL_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_count    <= 16'd0;
      wr_count    <= 16'd0;
      busy_cycles <= 16'd0;
    end else begin
      if (last_acc && !lat_we && rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
      if (last_acc &&  lat_we && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
      if (state != IDLE && busy_cycles != 16'hFFFF) busy_cycles <= busy_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ram_busctl.sv
// Bench for ram_busctl: a WAIT=0 and a WAIT=3 instance, each with a RAM model.
`timescale 1ns/1ps
module tb_ram_busctl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid [2];
  logic        req_we    [2];
  logic [15:0] req_addr  [2];
  logic [7:0]  req_wdata [2];
  logic        req_ready [2];
  logic        rsp_valid [2];
  logic [7:0]  rsp_rdata [2];
  logic [15:0] addr_o    [2];
  logic        cs_o [2], oe_o [2], we_o [2];
  logic [7:0]  data_o    [2];
  logic [7:0]  mem [2][65536];
`ifdef RAM_BUSCTL_STATS_EN
  logic [15:0] rd_cnt [2], wr_cnt [2], busy_cnt [2];
`endif

  generate
    for (genvar g = 0; g < 2; g++) begin : u
      ram_busctl_if bif();
      tri0 [7:0] data;
      assign bif.req_valid = req_valid[g];
      assign bif.req_we    = req_we[g];
      assign bif.req_addr  = req_addr[g];
      assign bif.req_wdata = req_wdata[g];
      assign req_ready[g]  = bif.req_ready;
      assign rsp_valid[g]  = bif.rsp_valid;
      assign rsp_rdata[g]  = bif.rsp_rdata;
      // RAM drives only on a pure read strobe; otherwise the net floats to 0.
      assign data = (cs_o[g] && oe_o[g] && !we_o[g]) ? mem[g][addr_o[g]] : 8'bz;
      assign data_o[g] = data;
      ram_busctl #(.WAIT(g * 3)) dut (
        .clk(clk), .rst(rst), .bus(bif.slave), .addr(addr_o[g]), .data(data),
        .cs(cs_o[g]), .oe(oe_o[g]), .we(we_o[g])
`ifdef RAM_BUSCTL_STATS_EN
        , .rd_count(rd_cnt[g]), .wr_count(wr_cnt[g]), .busy_cycles(busy_cnt[g])
`endif
      );
    end
  endgenerate

  always @(posedge clk)
    for (int i = 0; i < 2; i++)
      if (cs_o[i] && we_o[i]) mem[i][addr_o[i]] <= data_o[i];

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] ref_mem [int];
  logic [7:0] last_rd [2];
  int exp_rd [2], exp_wr [2], exp_busy [2];

  // One transaction on instance g, checked cycle by cycle against its timeline.
  task automatic do_txn(input int g, input bit w, input logic [15:0] a, input logic [7:0] d);
    int wt   = (g == 0) ? 0 : 3;
    int last = w ? 3 + wt : 4 + wt;
    int key  = g * 65536 + int'(a);
    logic [7:0] rv, exp_d, exp_r;
    logic [4:0] exp_s, obs_s;
    bit acc;
    rv = w ? 8'h00 : ref_mem[key];
    req_we[g] = w; req_addr[g] = a; req_wdata[g] = d; req_valid[g] = 1'b1;
    for (int k = 0; k <= last; k++) begin
      @(negedge clk);
      acc   = (k >= 2 && k <= 2 + wt);
      exp_s = {acc, acc && !w, acc && w, k == 3 + wt, k == 0 || k >= last};
      obs_s = {cs_o[g], oe_o[g], we_o[g], rsp_valid[g], req_ready[g]};
      n_vec++;
      if (obs_s !== exp_s) begin
        n_err++;
        $display("FAIL strobes dut%0d we=%0d k=%0d cs/oe/we/rsp/rdy got %b want %b", g, w, k, obs_s, exp_s);
      end
      exp_d = (w && k >= 1 && k <= 2 + wt) ? d : (!w && acc) ? rv : 8'h00;
      n_vec++;
      if (data_o[g] !== exp_d) begin
        n_err++;
        $display("FAIL data dut%0d k=%0d got %h want %h", g, k, data_o[g], exp_d);
      end
      if (k >= 1 && k <= 2 + wt) begin
        n_vec++;
        if (addr_o[g] !== a) begin
          n_err++;
          $display("FAIL addr dut%0d k=%0d got %h want %h", g, k, addr_o[g], a);
        end
      end
      exp_r = (!w && k >= 3 + wt) ? rv : last_rd[g];
      n_vec++;
      if (rsp_rdata[g] !== exp_r) begin
        n_err++;
        $display("FAIL rdata dut%0d k=%0d got %h want %h", g, k, rsp_rdata[g], exp_r);
      end
      @(posedge clk); #1;
      if (k == 0) req_valid[g] = 1'b0;
    end
    if (w) begin
      ref_mem[key] = d; exp_wr[g]++; exp_busy[g] += 2 + wt;
    end else begin
      last_rd[g] = rv; exp_rd[g]++; exp_busy[g] += 3 + wt;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      n_vec++;
      if ({cs_o[g], oe_o[g], we_o[g], rsp_valid[g], req_ready[g], addr_o[g], rsp_rdata[g], data_o[g]} !== 37'd0) begin
        n_err++;
        $display("FAIL reset_vals dut%0d got %b %h %h %h want 0", g,
                 {cs_o[g], oe_o[g], we_o[g], rsp_valid[g], req_ready[g]}, addr_o[g], rsp_rdata[g], data_o[g]);
      end
    end
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      n_vec++;
      if (req_ready[g] !== 1'b1) begin
        n_err++;
        $display("FAIL ready_after_reset dut%0d got %b want 1", g, req_ready[g]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_abort();
    req_we[0] = 1'b1; req_addr[0] = 16'h0BAD; req_wdata[0] = 8'h5A; req_valid[0] = 1'b1;
    @(posedge clk); #1 req_valid[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if ({cs_o[0], we_o[0], data_o[0]} !== {2'b11, 8'h5A}) begin
      n_err++;
      $display("FAIL abort_pre cs/we/data got %b%b %h want 11 5a", cs_o[0], we_o[0], data_o[0]);
    end
    #1 rst = 1'b0;
    #1;
    n_vec++;
    if ({cs_o[0], oe_o[0], we_o[0], rsp_valid[0], req_ready[0], data_o[0]} !== 13'd0) begin
      n_err++;
      $display("FAIL abort_drop strobes %b data %h want 0", {cs_o[0], oe_o[0], we_o[0], rsp_valid[0], req_ready[0]}, data_o[0]);
    end
    @(posedge clk); #1 rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_vec++;
      if (rsp_valid[0] !== 1'b0 || (c == 0 && req_ready[0] !== 1'b1)) begin
        n_err++;
        $display("FAIL abort_after c=%0d rsp=%b rdy=%b want rsp 0 rdy 1", c, rsp_valid[0], req_ready[0]);
      end
      @(posedge clk); #1;
    end
    for (int g = 0; g < 2; g++) begin
      last_rd[g] = 8'h00; exp_rd[g] = 0; exp_wr[g] = 0; exp_busy[g] = 0;
    end
  endtask

  task automatic test_write_read();
    do_txn(0, 1'b1, 16'h0012, 8'hA5);
    n_vec++;
    if (mem[0][16'h0012] !== 8'hA5) begin
      n_err++;
      $display("FAIL ram_content got %h want a5", mem[0][16'h0012]);
    end
    do_txn(0, 1'b0, 16'h0012, 8'h00);
  endtask

  task automatic test_wait3();
    do_txn(1, 1'b1, 16'hFFFF, 8'h3C);
    do_txn(1, 1'b0, 16'hFFFF, 8'h00);
    do_txn(1, 1'b1, 16'h0000, 8'hC3);
    do_txn(1, 1'b0, 16'h0000, 8'h00);
  endtask

  task automatic test_back_to_back();
    bit          bw [3] = '{1'b1, 1'b0, 1'b1};
    logic [15:0] ba [3] = '{16'h0001, 16'h0001, 16'h0002};
    logic [7:0]  bd [3] = '{8'h11, 8'h00, 8'h22};
    int hs [$];
    int rs [$];
    int idx = 0;
    bit hit;
    req_we[0] = bw[0]; req_addr[0] = ba[0]; req_wdata[0] = bd[0]; req_valid[0] = 1'b1;
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      hit = req_valid[0] && req_ready[0];
      if (hit) hs.push_back(c);
      if (rsp_valid[0]) rs.push_back(c);
      if (c == 6) begin
        n_vec++;
        if ({cs_o[0], oe_o[0], we_o[0], data_o[0], rsp_rdata[0]} !== {3'b000, 8'h00, 8'h11}) begin
          n_err++;
          $display("FAIL b2b_turn strobes %b data %h rdata %h want 000 00 11",
                   {cs_o[0], oe_o[0], we_o[0]}, data_o[0], rsp_rdata[0]);
        end
      end
      @(posedge clk); #1;
      if (hit) begin
        idx++;
        if (idx < 3) begin
          req_we[0] = bw[idx]; req_addr[0] = ba[idx]; req_wdata[0] = bd[idx];
        end else req_valid[0] = 1'b0;
      end
    end
    n_vec++;
    if (hs.size() != 3 || hs[0] != 0 || hs[1] != 3 || hs[2] != 7) begin
      n_err++;
      $display("FAIL b2b_handshakes got %p want 0 3 7", hs);
    end
    n_vec++;
    if (rs.size() != 3 || rs[0] != 3 || rs[1] != 6 || rs[2] != 10) begin
      n_err++;
      $display("FAIL b2b_responses got %p want 3 6 10", rs);
    end
    ref_mem[1] = 8'h11; ref_mem[2] = 8'h22; last_rd[0] = 8'h11;
    exp_wr[0] += 2; exp_rd[0] += 1; exp_busy[0] += 7;
  endtask

  task automatic test_random();
    int g, key;
    bit w;
    logic [15:0] a;
    for (int n = 0; n < 40; n++) begin
      g = int'($urandom_range(0, 1));
      a = 16'h0100 + 16'($urandom_range(0, 7));
      key = g * 65536 + int'(a);
      w = ($urandom_range(0, 1) == 1) || !ref_mem.exists(key);
      do_txn(g, w, a, 8'($urandom));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
  endtask

`ifdef RAM_BUSCTL_STATS_EN
  task automatic test_stats();
    for (int g = 0; g < 2; g++) begin
      n_vec++;
      if (rd_cnt[g] !== 16'(exp_rd[g]) || wr_cnt[g] !== 16'(exp_wr[g]) || busy_cnt[g] !== 16'(exp_busy[g])) begin
        n_err++;
        $display("FAIL stats dut%0d rd/wr/busy got %0d %0d %0d want %0d %0d %0d",
                 g, rd_cnt[g], wr_cnt[g], busy_cnt[g], exp_rd[g], exp_wr[g], exp_busy[g]);
      end
    end
  endtask
`endif

  initial begin
    for (int g = 0; g < 2; g++) begin
      req_valid[g] = 1'b0; req_we[g] = 1'b0; req_addr[g] = 16'h0; req_wdata[g] = 8'h0;
      last_rd[g] = 8'h00; exp_rd[g] = 0; exp_wr[g] = 0; exp_busy[g] = 0;
    end
    test_reset();
    test_abort();
    test_write_read();
    test_wait3();
    test_back_to_back();
    test_random();
`ifdef RAM_BUSCTL_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
